hash_des_arbiter: RTL and testbench
===================================

// Module: hash_des_arbiter
// PURPOSE
//  Shares one fullHashDES core between NUM_REQ requesters. Round-robin grant; streams
//  the granted requester's bytes into the core; waits for hash_ready; returns the
//  32-bit digest with a one-cycle done strobe to that requester. Sits between the
//  client ports and the single hash core instance.
// PARAMETERS
//  NUM_REQ     4      number of requesters (2..8)
//  LEN_W       64     message-length width, matches core C_in
//  TIMEOUT     1024   max cycles in WAIT before error abort
// PORTS
//  clk            in   1            system clock, single domain
//  rst            in   1            synchronous reset, active-high
//  req            in   NUM_REQ      per-requester job request, held until granted
//  req_len        in   NUM_REQ*64   per-requester message length in bytes
//  req_byte       in   NUM_REQ*8    per-requester message byte
//  req_byte_vld   in   NUM_REQ      byte valid
//  req_byte_rdy   out  NUM_REQ      byte accepted (one-hot to grantee, else 0)
//  grant          out  NUM_REQ      one-hot current owner, 0 in IDLE
//  done           out  NUM_REQ      one-cycle strobe, digest valid same cycle
//  err            out  NUM_REQ      one-cycle strobe, job aborted on timeout
//  digest         out  32           digest of last completed job, held until next
//  core_M_valid   out  1            to core M_valid
//  core_C_in      out  64           to core C_in, held stable for whole job
//  core_M         out  8            to core M
//  core_hash_rdy  in   1            from core hash_ready
//  core_digest    in   32           from core digest_final
// BEHAVIOUR
//  Reset (rst=1 at posedge): state IDLE, rr pointer=0; grant, req_byte_rdy, done, err,
//   core_M_valid = 0; core_C_in, core_M, digest = 0. Reset mid-job discards the job,
//   no done/err issued.
//  FSM IDLE -> LOAD -> STREAM | EMPTY -> WAIT -> FIN -> IDLE.
//  IDLE: if any req, pick first set bit at/after rr pointer (wrap) -> LOAD.
//  LOAD (1 cycle): grant one-hot, latch len into core_C_in and byte counter.
//   len==0 -> EMPTY, else STREAM.
//  EMPTY (1 cycle): core_M_valid=1, core_M=0 -> WAIT.
//  STREAM: req_byte_rdy[g]=1; on req_byte_vld[g] byte registered to core_M with
//   core_M_valid=1 next cycle, counter-1. Gaps (vld=0) give core_M_valid=0; core
//   tolerates pauses. Last byte (counter 1->0) -> WAIT. Max 1 byte/cycle.
//  WAIT: core_hash_rdy ignored on first WAIT cycle (stale level from prior job);
//   thereafter first cycle core_hash_rdy=1 -> FIN. Cycle count > TIMEOUT -> err[g]
//   strobe, -> IDLE.
//  FIN (1 cycle): digest <= core_digest, done[g]=1, rr pointer <= g+1 mod NUM_REQ,
//   grant cleared next cycle -> IDLE.
//  Latency: LOAD->first core_M_valid = 1 cycle; hash_rdy -> done = 1 cycle.
//  Requests deasserted before grant are dropped silently; req of grantee ignored
//   while job in flight. New req from grantee accepted only after back in IDLE.
//  Bytes with vld while not granted: rdy=0, not consumed. len up to 2^64-1,
//   counter never wraps (stops at 0).
//  rr pointer after timeout also advances (failed owner loses priority).
// STRUCTURE
//  hash_arb_pkg: state enum (IDLE,LOAD,STREAM,EMPTY,WAIT,FIN), LEN_W, DIGEST_W=32,
//   BYTE_W=8 constants.
//  Sub-module rr_arbiter (NUM_REQ): req vector + pointer -> one-hot grant, valid.
//  Core instantiated outside; core_rst_n driven at top as ~rst.
// TESTING
//  T1 empty: req[0], len=0 -> one core_M_valid pulse, C_in=0; done[0], digest=956F7883.
//  T2 1 byte: req[1], len=1, byte 8'h41 -> exactly 1 core_M_valid, done[1], digest
//   equals direct-core result for "A".
//  T3 156 bytes 0..155 continuous, then same with 2 idle cycles between bytes ->
//   identical digests; core_M_valid count=156 both times.
//  T4 contention: req=4'b1111 same cycle, 4 bytes each -> grant order 0,1,2,3; then
//   req=4'b1001 -> order 0,3 after ptr wrap; no interleaved bytes across jobs.
//  T5 timeout: core model holds hash_ready=0 -> err[g] at TIMEOUT+1 WAIT cycles,
//   no done, next requester granted.
//  T6 rst=1 mid-STREAM (byte 50 of 255) -> all outputs 0 next cycle; restart 255-byte
//   job -> digest differs from 156-byte digest, matches core reference.

Source files
------------

// File: rtl/hash_arb_pkg.sv
// Shared constants and FSM state type for the hash core arbiter.
package hash_arb_pkg;

    localparam int LEN_W    = 64;
    localparam int DIGEST_W = 32;
    localparam int BYTE_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        EMPTY,
        WAIT,
        FIN
    } state_e;

endpackage

// File: rtl/hash_des_arbiter_if.sv
// Client-side bundle between the requesters and the arbiter.
interface hash_des_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import hash_arb_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ*BYTE_W-1:0] req_byte;
    logic [NUM_REQ-1:0]        req_byte_vld;
    logic [NUM_REQ-1:0]        req_byte_rdy;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ-1:0]        err;
    logic [DIGEST_W-1:0]       digest;

    modport master (
        output req, req_len, req_byte, req_byte_vld,
        input  req_byte_rdy, grant, done, err, digest
    );

    modport slave (
        input  req, req_len, req_byte, req_byte_vld,
        output req_byte_rdy, grant, done, err, digest
    );

endinterface

// File: rtl/hash_des_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);
    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // scan highest offset first so the nearest request wins
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                valid = 1'b1;
                idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
        gnt = valid ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/hash_des_arbiter.sv
// Shares one hash core between NUM_REQ clients: round-robin grant, byte
// streaming into the core, digest return with a done/err strobe.
module hash_des_arbiter
    import hash_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    hash_des_arbiter_if.slave   cli,
    output logic                core_rst_n,
    output logic                core_M_valid,
    output logic [LEN_W-1:0]    core_C_in,
    output logic [BYTE_W-1:0]   core_M,
    input  logic                core_hash_rdy,
    input  logic [DIGEST_W-1:0] core_digest
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    state_e              state_q,  state_d;
    logic [IDX_W-1:0]    owner_q,  owner_d;
    logic [IDX_W-1:0]    ptr_q,    ptr_d;
    logic [NUM_REQ-1:0]  grant_q,  grant_d;
    logic [NUM_REQ-1:0]  rdy_q,    rdy_d;
    logic [NUM_REQ-1:0]  done_q,   done_d;
    logic [NUM_REQ-1:0]  err_q,    err_d;
    logic [DIGEST_W-1:0] digest_q, digest_d;
    logic                mvalid_q, mvalid_d;
    logic [LEN_W-1:0]    c_in_q,   c_in_d;
    logic [BYTE_W-1:0]   m_q,      m_d;
    logic [LEN_W-1:0]    cnt_q,    cnt_d;
    logic [WCNT_W-1:0]   wcnt_q,   wcnt_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_valid;
    logic [LEN_W-1:0]    cur_len;
    logic [BYTE_W-1:0]   cur_byte;
    logic                cur_vld;
    logic [IDX_W-1:0]    nxt_ptr;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (cli.req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign cur_len  = cli.req_len[int'(owner_q)*LEN_W +: LEN_W];
    assign cur_byte = cli.req_byte[int'(owner_q)*BYTE_W +: BYTE_W];
    assign cur_vld  = cli.req_byte_vld[owner_q] & rdy_q[owner_q];
    assign nxt_ptr  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        rdy_d    = rdy_q;
        done_d   = '0;
        err_d    = '0;
        digest_d = digest_q;
        mvalid_d = 1'b0;
        c_in_d   = c_in_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    owner_d = arb_idx;
                    grant_d = arb_gnt;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                c_in_d = cur_len;
                cnt_d  = cur_len;
                if (cur_len == '0) begin
                    state_d = EMPTY;
                end else begin
                    rdy_d   = grant_q;
                    state_d = STREAM;
                end
            end
            EMPTY: begin
                mvalid_d = 1'b1;
                m_d      = '0;
                wcnt_d   = WCNT_W'(TIMEOUT);
                state_d  = WAIT;
            end
            STREAM: begin
                if (cur_vld && cnt_q != '0) begin
                    m_d      = cur_byte;
                    mvalid_d = 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        rdy_d   = '0;
                        wcnt_d  = WCNT_W'(TIMEOUT);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // wcnt still at its load value marks the first WAIT cycle,
                // where hash_rdy may be left over from the previous job
                if (core_hash_rdy && wcnt_q != WCNT_W'(TIMEOUT)) begin
                    digest_d = core_digest;
                    done_d   = grant_q;
                    ptr_d    = nxt_ptr;
                    state_d  = FIN;
                end else if (wcnt_q == '0) begin
                    err_d    = grant_q;
                    grant_d  = '0;
                    ptr_d    = nxt_ptr;
                    state_d  = IDLE;
                end else begin
                    wcnt_d   = wcnt_q - 1'b1;
                end
            end
            FIN: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            rdy_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            digest_q <= '0;
            mvalid_q <= 1'b0;
            c_in_q   <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            rdy_q    <= rdy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            digest_q <= digest_d;
            mvalid_q <= mvalid_d;
            c_in_q   <= c_in_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign cli.grant        = grant_q;
    assign cli.req_byte_rdy = rdy_q;
    assign cli.done         = done_q;
    assign cli.err          = err_q;
    assign cli.digest       = digest_q;
    assign core_M_valid     = mvalid_q;
    assign core_C_in        = c_in_q;
    assign core_M           = m_q;
    assign core_rst_n       = ~rst;

endmodule

// File: tb/tb_hash_des_arbiter.sv
// Bench for hash_des_arbiter: FNV-1a stand-in core, per-cycle model of grant
// order, byte stream, done/err timing and digest.
module tb_hash_des_arbiter;
    import hash_arb_pkg::*;

    localparam int N  = 4;
    localparam int TO = 20;
    localparam logic [31:0] FNV0 = 32'h811C9DC5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hash_des_arbiter_if #(.NUM_REQ(N)) cli();
    logic        core_rst_n;
    logic        core_M_valid;
    logic [63:0] core_C_in;
    logic [7:0]  core_M;
    logic        core_hash_rdy;
    logic [31:0] core_digest;

    hash_des_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .cli           (cli),
        .core_rst_n    (core_rst_n),
        .core_M_valid  (core_M_valid),
        .core_C_in     (core_C_in),
        .core_M        (core_M),
        .core_hash_rdy (core_hash_rdy),
        .core_digest   (core_digest)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] fnv(input logic [31:0] h, input logic [7:0] b);
        return (h ^ {24'h0, b}) * 32'd16777619;
    endfunction

    function automatic logic [31:0] core_fold(input logic [31:0] h, input logic [63:0] len,
                                              input logic [7:0] b);
        return (len == 64'd0) ? h : fnv(h, b);
    endfunction

    // stand-in core: hashes received bytes, raises hash_ready after a random delay,
    // leaves it high until the next job's first byte
    bit          core_hold = 1'b0;
    logic [31:0] c_h;
    longint unsigned c_cnt;
    int          c_dly;
    always @(posedge clk) begin
        if (!core_rst_n) begin
            core_hash_rdy <= 1'b0;
            core_digest   <= '0;
            c_h           <= FNV0;
            c_cnt         <= 0;
            c_dly         <= -1;
        end else if (core_M_valid) begin
            core_hash_rdy <= 1'b0;
            c_h <= core_fold((c_cnt == 0) ? FNV0 : c_h, core_C_in, core_M);
            if (c_cnt + 1 >= ((core_C_in == 64'd0) ? 64'd1 : core_C_in)) begin
                c_cnt <= 0;
                c_dly <= int'($urandom_range(0, 4));
            end else begin
                c_cnt <= c_cnt + 1;
                c_dly <= -1;
            end
        end else if (c_dly == 0) begin
            if (!core_hold) begin
                core_hash_rdy <= 1'b1;
                core_digest   <= c_h;
                c_dly         <= -1;
            end
        end else if (c_dly > 0) begin
            c_dly <= c_dly - 1;
        end
    end

    // requester side
    bit         r_pend [N];
    bit         r_gnt  [N];
    bit         xfer   [N];
    bit         r_rgap [N];
    int         r_len  [N];
    int         r_pos  [N];
    int         r_wait [N];
    int         r_gap  [N];
    logic [7:0] r_msg  [N][256];

    // reference model
    int          m_ptr = 0;
    int          m_owner = -1;
    int          m_len, m_tgt, m_mv, m_last_mv, m_rdy_cyc, m_last_mvcnt;
    int          cyc = 0;
    int          err_cnt = 0;
    logic [31:0] m_exp_dig;
    logic [31:0] m_last_dig = '0;
    logic [7:0]  m_q[$];
    int          done_order[$];
    logic [N-1:0] prev_req = '0;
    logic [N-1:0] prev_grant = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [31:0] msg_digest(input int i);
        logic [31:0] h = FNV0;
        for (int j = 0; j < r_len[i]; j++) h = fnv(h, r_msg[i][j]);
        return h;
    endfunction

    function automatic bit busy();
        bit b = (m_owner >= 0);
        for (int i = 0; i < N; i++) b |= r_pend[i];
        return b;
    endfunction

    task automatic check_outputs();
        int e;
        if (cli.err != '0) begin
            if (m_owner < 0) chk("err_owner", 64'(cli.err), 0);
            else begin
                chk("err_onehot", 64'(cli.err), 64'(1 << m_owner));
                chk("err_latency", 64'(cyc - m_last_mv), 64'(TO + 1));
                chk("err_expected", 64'(core_hold), 1);
                m_ptr = (m_owner + 1) % N;
                r_pend[m_owner] = 1'b0;
                r_gnt[m_owner]  = 1'b0;
                m_last_mvcnt = m_mv;
                m_owner = -1;
                err_cnt++;
            end
        end
        if (prev_grant == '0 && cli.grant != '0) begin
            e = rr_pick(prev_req, m_ptr);
            chk("grant_pick", 64'(cli.grant), (e < 0) ? 64'd0 : 64'(1 << e));
            if (e >= 0) begin
                m_owner = e;
                r_gnt[e] = 1'b1;
                m_len = r_len[e];
                m_q.delete();
                if (m_len == 0) m_q.push_back(8'h00);
                for (int j = 0; j < m_len; j++) m_q.push_back(r_msg[e][j]);
                m_tgt = (m_len == 0) ? 1 : m_len;
                m_exp_dig = msg_digest(e);
                m_mv = 0;
                m_last_mv = -1;
                m_rdy_cyc = -1;
            end
        end else if (m_owner >= 0) chk("grant_hold", 64'(cli.grant), 64'(1 << m_owner));
        else chk("grant_idle", 64'(cli.grant), 0);
        chk("rdy_subset", 64'(cli.req_byte_rdy & ~cli.grant), 0);
        if (core_M_valid) begin
            if (m_owner < 0 || m_q.size() == 0) chk("extra_byte", 64'(core_M_valid), 0);
            else begin
                chk("core_M", 64'(core_M), 64'(m_q.pop_front()));
                chk("core_C_in", core_C_in, 64'(m_len));
                m_mv++;
                m_last_mv = cyc;
            end
        end
        if (m_owner >= 0 && m_q.size() == 0 && m_last_mv >= 0 && cyc > m_last_mv &&
            m_rdy_cyc < 0 && core_hash_rdy)
            m_rdy_cyc = cyc;
        if (cli.done != '0) begin
            if (m_owner < 0) chk("done_owner", 64'(cli.done), 0);
            else begin
                chk("done_onehot", 64'(cli.done), 64'(1 << m_owner));
                chk("done_digest", 64'(cli.digest), 64'(m_exp_dig));
                chk("done_bytes", 64'(m_mv), 64'(m_tgt));
                chk("done_latency", 64'(cyc), 64'(m_rdy_cyc + 1));
                m_last_dig = m_exp_dig;
                done_order.push_back(m_owner);
                m_ptr = (m_owner + 1) % N;
                r_pend[m_owner] = 1'b0;
                r_gnt[m_owner]  = 1'b0;
                m_last_mvcnt = m_mv;
                m_owner = -1;
            end
        end else chk("digest_hold", 64'(cli.digest), 64'(m_last_dig));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            cli.req[i] = r_pend[i] & ~r_gnt[i];
            cli.req_len[i*64 +: 64] = 64'(r_len[i]);
            if (r_gnt[i] && r_pos[i] < r_len[i]) begin
                if (r_wait[i] > 0) begin
                    cli.req_byte_vld[i] = 1'b0;
                    r_wait[i]--;
                end else begin
                    cli.req_byte_vld[i] = 1'b1;
                    cli.req_byte[i*8 +: 8] = r_msg[i][r_pos[i]];
                end
            end else if (r_pend[i] && !r_gnt[i]) begin
                // bytes offered before grant must not be consumed
                cli.req_byte_vld[i] = 1'($urandom_range(0, 1));
                cli.req_byte[i*8 +: 8] = 8'($urandom);
            end else begin
                cli.req_byte_vld[i] = 1'b0;
            end
            xfer[i] = cli.req_byte_vld[i] & cli.req_byte_rdy[i];
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) begin
                r_pos[i]++;
                r_wait[i] = r_rgap[i] ? int'($urandom_range(0, r_gap[i])) : r_gap[i];
            end
        end
        if (rst) begin
            chk("rst_grant",  64'(cli.grant), 0);
            chk("rst_rdy",    64'(cli.req_byte_rdy), 0);
            chk("rst_done",   64'(cli.done), 0);
            chk("rst_err",    64'(cli.err), 0);
            chk("rst_mvalid", 64'(core_M_valid), 0);
            chk("rst_c_in",   core_C_in, 0);
            chk("rst_m",      64'(core_M), 0);
            chk("rst_digest", 64'(cli.digest), 0);
            m_owner = -1;
            m_ptr = 0;
            m_last_dig = '0;
            m_q.delete();
            for (int i = 0; i < N; i++) begin
                r_pend[i] = 1'b0;
                r_gnt[i]  = 1'b0;
                xfer[i]   = 1'b0;
            end
        end else begin
            check_outputs();
        end
        drive();
        prev_grant = cli.grant;
        prev_req   = cli.req;
    endtask

    task automatic submit(input int i, input int len, input int gap, input bit rgap);
        r_pend[i] = 1'b1;
        r_gnt[i]  = 1'b0;
        r_len[i]  = len;
        r_pos[i]  = 0;
        r_gap[i]  = gap;
        r_rgap[i] = rgap;
        r_wait[i] = 0;
        for (int j = 0; j < 256; j++) r_msg[i][j] = 8'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy() && k < budget) begin
            step();
            k++;
        end
        chk("idle_timeout", 64'(busy()), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [31:0] d156;
    int sel, e0, k;

    initial begin
        cli.req = '0;
        cli.req_len = '0;
        cli.req_byte = '0;
        cli.req_byte_vld = '0;
        for (int i = 0; i < N; i++) begin
            r_pend[i] = 0; r_gnt[i] = 0; xfer[i] = 0; r_len[i] = 0; r_pos[i] = 0;
            r_wait[i] = 0; r_gap[i] = 0; r_rgap[i] = 0;
        end
        do_reset();
        step();
        step();

        // empty message
        submit(0, 0, 0, 1'b0);
        wait_idle(200);
        chk("t1_digest", 64'(cli.digest), 64'h811C9DC5);
        chk("t1_mv", 64'(m_last_mvcnt), 1);

        // single byte "A"
        submit(1, 1, 0, 1'b0);
        r_msg[1][0] = 8'h41;
        wait_idle(200);
        chk("t2_digest", 64'(cli.digest), 64'hC40BF6CC);
        chk("t2_mv", 64'(m_last_mvcnt), 1);

        // 156 bytes, continuous then with two-cycle gaps
        submit(2, 156, 0, 1'b0);
        for (int j = 0; j < 156; j++) r_msg[2][j] = 8'(j);
        wait_idle(2000);
        d156 = cli.digest;
        chk("t3a_mv", 64'(m_last_mvcnt), 156);
        submit(2, 156, 2, 1'b0);
        for (int j = 0; j < 156; j++) r_msg[2][j] = 8'(j);
        wait_idle(3000);
        chk("t3_same_digest", 64'(cli.digest), 64'(d156));
        chk("t3b_mv", 64'(m_last_mvcnt), 156);

        // contention from a fresh pointer
        do_reset();
        done_order.delete();
        for (int i = 0; i < N; i++) submit(i, 4, 1, 1'b1);
        wait_idle(1000);
        chk("t4_order_len", 64'(done_order.size()), 4);
        for (int j = 0; j < 4; j++) chk($sformatf("t4_order%0d", j), 64'(done_order[j]), 64'(j));
        done_order.delete();
        submit(0, 4, 0, 1'b0);
        submit(3, 4, 0, 1'b0);
        wait_idle(1000);
        chk("t4b_order_len", 64'(done_order.size()), 2);
        chk("t4b_order0", 64'(done_order[0]), 0);
        chk("t4b_order1", 64'(done_order[1]), 3);

        // timeout abort, then next requester served
        core_hold = 1'b1;
        done_order.delete();
        submit(1, 3, 0, 1'b0);
        submit(2, 3, 0, 1'b0);
        e0 = err_cnt;
        k = 0;
        while (err_cnt == e0 && k < 500) begin
            step();
            k++;
        end
        chk("t5_err_seen", 64'(err_cnt), 64'(e0 + 1));
        core_hold = 1'b0;
        wait_idle(500);
        chk("t5_done_len", 64'(done_order.size()), 1);
        chk("t5_next_owner", 64'(done_order[0]), 2);

        // reset in the middle of a 255-byte stream, then rerun
        submit(0, 255, 0, 1'b0);
        k = 0;
        while (r_pos[0] < 50 && k < 1000) begin
            step();
            k++;
        end
        chk("t6_reached_50", 64'(r_pos[0] >= 50), 1);
        do_reset();
        submit(0, 255, 0, 1'b0);
        wait_idle(3000);
        chk("t6_mv", 64'(m_last_mvcnt), 255);
        chk("t6_differs", 64'(cli.digest != d156), 1);

        // random traffic
        for (int it = 0; it < 600; it++) begin
            step();
            if ($urandom_range(0, 3) == 0) begin
                sel = int'($urandom_range(0, N - 1));
                if (!r_pend[sel])
                    submit(sel, int'($urandom_range(0, 24)), int'($urandom_range(0, 2)), 1'b1);
            end
        end
        wait_idle(4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
